// File: rtl/phy_tx_sched.sv
// Two-port round-robin packet scheduler feeding phy_tx: one packet at a time,
// fixed idle gap after each packet, orphan (non-sop) beats drained while idle.
module phy_tx_sched #(
  parameter int GAP = 2
) (
  input  logic        clock1,
  input  logic        reset_L,
  input  logic        tx_en,
  input  logic        req0_valid,
  input  logic        req0_sop,
  input  logic        req0_eop,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  input  logic        req1_sop,
  input  logic        req1_eop,
  input  logic [31:0] req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] data_out,
  output logic        valid,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [3:0] GAP_LEN = 4'(GAP);

  logic [1:0]  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        prio_q, prio_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic        elig0_s, elig1_s;
  logic        drain0_s, drain1_s;
  logic        send0_s, send1_s;
  logic        beat_valid_s, beat_eop_s;
  logic [31:0] beat_data_s;
  logic [8:0]  drop_sum_s;

  // Ready is a pure decode of state in SEND; in IDLE it only drains orphans.
  always_comb begin
    elig0_s      = req0_valid & req0_sop;
    elig1_s      = req1_valid & req1_sop;
    drain0_s     = (state_q == ST_IDLE) & req0_valid & ~req0_sop;
    drain1_s     = (state_q == ST_IDLE) & req1_valid & ~req1_sop;
    send0_s      = (state_q == ST_SEND) & ~gnt_q;
    send1_s      = (state_q == ST_SEND) & gnt_q;
    req0_ready   = reset_L & (send0_s | drain0_s);
    req1_ready   = reset_L & (send1_s | drain1_s);
    beat_valid_s = gnt_q ? req1_valid : req0_valid;
    beat_eop_s   = gnt_q ? req1_eop   : req0_eop;
    beat_data_s  = gnt_q ? req1_data  : req0_data;
    drop_sum_s   = {1'b0, drop_cnt_q} + {8'd0, drain0_s} + {8'd0, drain1_s};
  end

  // Next-state, datapath and counter updates.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    prio_d     = prio_q;
    gap_cnt_d  = gap_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    drop_cnt_d = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
    case (state_q)
      ST_IDLE: begin
        if (tx_en && (elig0_s || elig1_s)) begin
          state_d = ST_SEND;
          if (elig0_s && elig1_s) begin
            gnt_d = prio_q;
          end else begin
            gnt_d = elig1_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (beat_valid_s) begin
          valid_d = 1'b1;
          data_d  = beat_data_s;
          if (beat_eop_s) begin
            prio_d = ~gnt_q;
            if (gnt_q) begin
              pkt_cnt1_d = pkt_cnt1_q + 16'd1;
            end else begin
              pkt_cnt0_d = pkt_cnt0_q + 16'd1;
            end
            if (GAP_LEN == 4'd0) begin
              state_d = ST_IDLE;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LEN;
            end
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        // The gap cycle that sees a count of 1 is the last one.
        if (gap_cnt_q <= 4'd1) begin
          state_d   = ST_IDLE;
          gap_cnt_d = 4'd0;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = 4'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock1 or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      gap_cnt_q  <= 4'd0;
      data_q     <= 32'h0;
      valid_q    <= 1'b0;
      pkt_cnt0_q <= 16'd0;
      pkt_cnt1_q <= 16'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      prio_q     <= prio_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/phy_tx_sched.md
PHY_TX_SCHED -- requirements
Module: phy_tx_sched

Interface
REQ-001 SHALL have parameter GAP, default 2, giving the idle cycles inserted after each packet (legal range 0..15).
REQ-002 SHALL have port clock1, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset_L, input, 1, an asynchronous active-low reset.
REQ-004 SHALL have port tx_en, input, 1, which permits new packet grants while high.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 each, meaning a requester beat is present.
REQ-006 SHALL have ports req0_sop/req1_sop, input, 1 each, marking the first beat of a packet.
REQ-007 SHALL have ports req0_eop/req1_eop, input, 1 each, marking the last beat of a packet.
REQ-008 SHALL have ports req0_data/req1_data, input, 32 each, carrying the beat payload.
REQ-009 SHALL have ports req0_ready/req1_ready, output, 1 each; a beat is accepted when valid and ready are both high on the same edge.
REQ-010 SHALL have port data_out, output, 32, the word driven to the data_in port of phy_tx.
REQ-011 SHALL have port valid, output, 1, the qualifier driven to the valid port of phy_tx.
REQ-012 SHALL have ports pkt_cnt0/pkt_cnt1, output, 16 each, counting completed packets per requester.
REQ-013 SHALL have port drop_cnt, output, 8, counting discarded orphan beats.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, SEND and GAP.
REQ-016 In IDLE with tx_en=1, a port is eligible when valid=1 and sop=1; the FSM SHALL grant one eligible port, latch the grant and move to SEND on the next edge.
REQ-017 When both ports are eligible, the grant SHALL go to the port not granted last (round-robin); the pointer after reset SHALL favour port 0.
REQ-018 In SEND, readyN SHALL be 1 only for the granted port and SHALL be a registered-state decode, with no combinational path from any reqN_valid.
REQ-019 Each accepted beat SHALL appear on data_out with valid=1 exactly one clock1 cycle later (latency 1); valid SHALL be 0 on every other cycle.
REQ-020 If the granted port deasserts valid mid-packet, the FSM SHALL hold SEND and drive valid=0 for those cycles.
REQ-021 An accepted eop beat SHALL end the packet: the FSM moves to GAP (GAP>0) or IDLE (GAP=0), the pkt_cnt of the granted port increments with 16-bit wrap, and the round-robin pointer updates.
REQ-022 A beat with sop=1 and eop=1 SHALL be a legal one-word packet.
REQ-023 GAP SHALL last exactly GAP cycles, counted by a 4-bit down-counter, then return to IDLE; all readyN SHALL be 0 in GAP.
REQ-024 In IDLE, a port presenting valid=1 with sop=0 SHALL see ready=1; that beat SHALL be discarded and drop_cnt SHALL increment, saturating at 255. Both ports may be drained on the same edge, adding 2 to drop_cnt.
REQ-025 A drain (REQ-024) and a grant (REQ-016) SHALL NOT target the same port on the same cycle; a port with sop=1 is never drained.
REQ-026 With tx_en=0, the FSM SHALL issue no new grant but SHALL finish any packet in SEND and any GAP; orphan draining continues.
REQ-027 A sop=1 beat arriving on the granted port after the first beat SHALL be forwarded as ordinary data; no framing check applies inside SEND.
REQ-028 Minimum spacing between the sop beats of consecutive packets SHALL be len+GAP+1 cycles.

Reset
REQ-029 While reset_L=0, asynchronously: state=IDLE, round-robin pointer favours port 0, gap counter=0, data_out=32'h0, valid=0, req0_ready=req1_ready=0, pkt_cnt0=pkt_cnt1=0, drop_cnt=0, busy=0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; no counter increments for it, and after release the FSM restarts in IDLE.

Verification
REQ-031 A bench SHALL check: port0 sends a 3-word packet AABB0001..AABB0003 with GAP=2 -> valid high for 3 consecutive cycles, each word one cycle after acceptance, then 2 idle cycles, then IDLE; pkt_cnt0=1.
REQ-032 A bench SHALL check: both ports hold sop on every packet with 2-word packets -> grants alternate 0,1,0,1; after 4 packets pkt_cnt0=2 and pkt_cnt1=2.
REQ-033 A bench SHALL check: port1 presents 3 orphan beats (sop=0) while IDLE -> each is drained with ready=1, valid stays 0, drop_cnt=3; 300 orphan beats -> drop_cnt=255.
REQ-034 A bench SHALL check: tx_en falls on the 2nd beat of a 4-word packet -> all 4 words are output, GAP runs, then no grant is issued until tx_en=1.
REQ-035 A bench SHALL check: GAP=0 with back-to-back one-word packets from port0 -> valid pattern 1,0,1,0 (IDLE cycle between packets), words in order.
REQ-036 A bench SHALL check: reset_L pulsed low mid-packet -> outputs immediately take their reset values, and pkt_cnt0 is unchanged at 0.
